ms_alarm: RTL and testbench

//  Programmable alarm/interval timer that consumes the free-running millisecond count

---
 rtl/ms_alarm_if.sv | 40 ++++
 rtl/ms_alarm.sv | 154 +++++++++++++++
 tb/tb_ms_alarm.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ms_alarm_if.sv
// ----------------------------------------------------------------------------
// ms_alarm_if
//
// Purpose:
//   Configuration handshake between software-facing logic and the ms_alarm
//   timer. Carries an arm request with its delay and mode, plus the ready
//   indication returned by the timer.
//
// Signals:
//   cfg_valid     master -> slave   request to arm the alarm
//   cfg_ready     slave  -> master  timer can accept a request (idle)
//   cfg_delay     master -> slave   delay in ms, also the re-arm period
//   cfg_periodic  master -> slave   1 = periodic re-arm, 0 = one-shot
//
// Modports:
//   master  drives the request (software side / testbench)
//   slave   receives the request (ms_alarm)
// ----------------------------------------------------------------------------
interface ms_alarm_if #(
    parameter int CW = 32
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_delay;
    logic          cfg_periodic;

    modport master (
        output cfg_valid,
        output cfg_delay,
        output cfg_periodic,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_delay,
        input  cfg_periodic,
        output cfg_ready
    );
endinterface

// File: rtl/ms_alarm.sv
// ----------------------------------------------------------------------------
// ms_alarm
//
// Purpose:
//   Programmable alarm / interval timer driven by the free-running millisecond
//   count of the ms counter stage. Software arms it with a delay; the block
//   turns that into an absolute target count and raises a level interrupt once
//   the count reaches the target. The comparison is wrap-around safe. In
//   periodic mode the target is advanced by the period on every hit and hits
//   that arrive while the interrupt is still unacknowledged are counted as
//   overruns.
//
// Parameters:
//   CW      width of cnt, delay and target
//   MISS_W  width of the saturating overrun counter
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous reset, active low
//   cnt       ms count from the counter stage, free running, wraps to 0
//   cfg       configuration handshake (ms_alarm_if.slave):
//               cfg_valid / cfg_ready / cfg_delay / cfg_periodic
//   cancel    abort current operation, return to idle
//   irq       alarm pending (level), held until irq_ack
//   irq_ack   clears irq, single-cycle pulse
//   active    1 while armed or pending
//   target    current absolute target count
//   miss_cnt  periodic hits lost while irq was already pending (saturating)
// ----------------------------------------------------------------------------
module ms_alarm #(
    parameter int CW     = 32,
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW-1:0]     cnt,
    ms_alarm_if.slave         cfg,
    input  logic              cancel,
    input  logic              irq_ack,
    output logic              irq,
    output logic              active,
    output logic [CW-1:0]     target,
    output logic [MISS_W-1:0] miss_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    // Largest delay that still lies within half the counter range. Anything
    // longer would make the wrap-safe comparison treat the target as already
    // passed, so longer requests are clamped to this value.
    localparam logic [CW-1:0] MAX_DELAY = {1'b0, {(CW-1){1'b1}}};

    localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};

    state_t        state;
    logic [CW-1:0] period;
    logic          periodic;

    logic [CW-1:0] delay_clamped;
    logic [CW-1:0] diff;
    logic          hit;
    logic          cfg_fire;

    // Clamp the requested delay. A set top bit means the value is beyond
    // half range, which is exactly the case that has to be clamped.
    always_comb begin
        delay_clamped = cfg.cfg_delay;
        if (cfg.cfg_delay[CW-1]) begin
            delay_clamped = MAX_DELAY;
        end
    end

    // Wrap-safe "count has reached target" test: the modular difference
    // cnt - target is non-negative when viewed as a signed number, i.e. the
    // count is at or up to half a range past the target. A count that jumps
    // backwards simply reads as "not yet" until it climbs back to target.
    always_comb begin
        diff = cnt - target;
        hit  = (state == ST_ARMED) && !diff[CW-1];
    end

    // Handshake decode. Ready is a pure state decode so that software sees
    // it drop the cycle after a request is accepted. A cancel in the same
    // cycle suppresses the transfer.
    assign cfg.cfg_ready = (state == ST_IDLE);
    assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready && !cancel;
    assign active        = (state != ST_IDLE);

    // Main control. Cancel overrides everything and deliberately leaves the
    // target and overrun count untouched so software can inspect them after
    // aborting. In periodic mode the next target is derived from the old
    // target rather than from cnt, so the period does not drift when a hit
    // is detected late. An acknowledge arriving together with a periodic hit
    // is treated as consumed by the new hit: irq stays set and no overrun is
    // recorded, since software has just serviced the previous one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            irq      <= 1'b0;
            target   <= '0;
            period   <= '0;
            periodic <= 1'b0;
            miss_cnt <= '0;
        end else if (cancel) begin
            state <= ST_IDLE;
            irq   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_fire) begin
                        target   <= cnt + delay_clamped;
                        period   <= delay_clamped;
                        periodic <= cfg.cfg_periodic;
                        miss_cnt <= '0;
                        state    <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (hit) begin
                        irq <= 1'b1;
                        if (periodic) begin
                            target <= target + period;
                            if (irq && !irq_ack && (miss_cnt != MISS_MAX)) begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end else begin
                            state <= ST_PENDING;
                        end
                    end else if (irq_ack) begin
                        irq <= 1'b0;
                    end
                end

                ST_PENDING: begin
                    if (irq_ack) begin
                        irq   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_alarm.sv
// ----------------------------------------------------------------------------
// tb_ms_alarm
//
// Purpose:
//   Directed, self-checking bench for ms_alarm. The bench drives cnt directly
//   (jumping it to chosen values) and compares outputs against hand-computed
//   constants.
// ----------------------------------------------------------------------------
module tb_ms_alarm;

    logic        clk;
    logic        reset;
    logic [31:0] cnt;
    logic        cancel;
    logic        irq_ack;
    logic        irq;
    logic        active;
    logic [31:0] target;
    logic [7:0]  miss_cnt;

    int vectors;
    int miscompares;

    ms_alarm_if #(.CW(32)) cfg_bus ();

    ms_alarm #(
        .CW     (32),
        .MISS_W (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cnt      (cnt),
        .cfg      (cfg_bus),
        .cancel   (cancel),
        .irq_ack  (irq_ack),
        .irq      (irq),
        .active   (active),
        .target   (target),
        .miss_cnt (miss_cnt)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and log misses.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive all inputs for one cycle, then step past the next rising edge so
    // the caller samples settled registered outputs.
    task automatic applyStimulus(input logic [31:0] cnt_val, input logic valid,
                                 input logic [31:0] delay, input logic per,
                                 input logic canc, input logic ack);
        cnt                  = cnt_val;
        cfg_bus.cfg_valid    = valid;
        cfg_bus.cfg_delay    = delay;
        cfg_bus.cfg_periodic = per;
        cancel               = canc;
        irq_ack              = ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors              = 0;
        miscompares          = 0;
        reset                = 1'b0;
        cnt                  = '0;
        cfg_bus.cfg_valid    = 1'b0;
        cfg_bus.cfg_delay    = '0;
        cfg_bus.cfg_periodic = 1'b0;
        cancel               = 1'b0;
        irq_ack              = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        checkOutput("rst_target", target, 32'd0);
        checkOutput("rst_miss", {24'd0, miss_cnt}, 32'd0);
        checkOutput("rst_active", {31'd0, active}, 32'd0);
        checkOutput("rst_ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: one-shot without wrap
        $display("[TB] one-shot");
        applyStimulus(32'd100, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_target", target, 32'd105);
        checkOutput("t1_active", {31'd0, active}, 32'd1);
        checkOutput("t1_ready", {31'd0, cfg_bus.cfg_ready}, 32'd0);
        applyStimulus(32'd104, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_early_irq", {31'd0, irq}, 32'd0);
        applyStimulus(32'd105, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_irq", {31'd0, irq}, 32'd1);
        checkOutput("t1_target_hold", target, 32'd105);
        checkOutput("t1_ready_pend", {31'd0, cfg_bus.cfg_ready}, 32'd0);
        applyStimulus(32'd106, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_ack_irq", {31'd0, irq}, 32'd0);
        checkOutput("t1_ack_active", {31'd0, active}, 32'd0);
        checkOutput("t1_ack_ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);

        // 2: target wraps past zero
        $display("[TB] wrap-around");
        applyStimulus(32'hFFFF_FFFD, 1'b1, 32'd6, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_target", target, 32'd3);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'hFFFF_FFFE + i, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            checkOutput("t2_no_irq", {31'd0, irq}, 32'd0);
        end
        applyStimulus(32'd3, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_irq", {31'd0, irq}, 32'd1);
        applyStimulus(32'd4, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_ack_irq", {31'd0, irq}, 32'd0);

        // 3: periodic, never acknowledged, overruns saturate
        $display("[TB] periodic overrun");
        applyStimulus(32'd1000, 1'b1, 32'd4, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_target0", target, 32'd1004);
        applyStimulus(32'd1004, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_h1_irq", {31'd0, irq}, 32'd1);
        checkOutput("t3_h1_target", target, 32'd1008);
        checkOutput("t3_h1_miss", {24'd0, miss_cnt}, 32'd0);
        checkOutput("t3_h1_active", {31'd0, active}, 32'd1);
        applyStimulus(32'd1008, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_h2_miss", {24'd0, miss_cnt}, 32'd1);
        applyStimulus(32'd1012, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_h3_miss", {24'd0, miss_cnt}, 32'd2);
        applyStimulus(32'd1016, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_h4_miss", {24'd0, miss_cnt}, 32'd3);
        checkOutput("t3_h4_target", target, 32'd1020);
        for (int i = 0; i < 260; i++) begin
            applyStimulus(32'd2220, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("t3_sat_miss", {24'd0, miss_cnt}, 32'd255);
        checkOutput("t3_sat_target", target, 32'd2060);
        applyStimulus(32'd2220, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_cancel_irq", {31'd0, irq}, 32'd0);
        checkOutput("t3_cancel_active", {31'd0, active}, 32'd0);
        checkOutput("t3_cancel_miss", {24'd0, miss_cnt}, 32'd255);
        checkOutput("t3_cancel_target", target, 32'd2060);

        // 4: periodic hit coinciding with acknowledge
        $display("[TB] hit with ack");
        applyStimulus(32'd0, 1'b1, 32'd10, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_rearm_miss", {24'd0, miss_cnt}, 32'd0);
        checkOutput("t4_target0", target, 32'd10);
        applyStimulus(32'd10, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_h1_irq", {31'd0, irq}, 32'd1);
        applyStimulus(32'd20, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_hack_irq", {31'd0, irq}, 32'd1);
        checkOutput("t4_hack_miss", {24'd0, miss_cnt}, 32'd0);
        checkOutput("t4_hack_target", target, 32'd30);
        applyStimulus(32'd25, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_ack_irq", {31'd0, irq}, 32'd0);
        checkOutput("t4_ack_active", {31'd0, active}, 32'd1);
        applyStimulus(32'd30, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_h3_irq", {31'd0, irq}, 32'd1);
        checkOutput("t4_h3_miss", {24'd0, miss_cnt}, 32'd0);
        applyStimulus(32'd31, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // 5: cancel in ARMED, in PENDING, and alongside a request in IDLE
        $display("[TB] cancel");
        applyStimulus(32'd0, 1'b1, 32'd100, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_armed", {31'd0, active}, 32'd1);
        applyStimulus(32'd1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_armed_cancel_active", {31'd0, active}, 32'd0);
        checkOutput("t5_armed_cancel_ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
        applyStimulus(32'd50, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_d0_target", target, 32'd50);
        applyStimulus(32'd50, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_d0_irq", {31'd0, irq}, 32'd1);
        applyStimulus(32'd51, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_pend_cancel_irq", {31'd0, irq}, 32'd0);
        checkOutput("t5_pend_cancel_active", {31'd0, active}, 32'd0);
        applyStimulus(32'd60, 1'b1, 32'd7, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_idle_cancel_active", {31'd0, active}, 32'd0);
        checkOutput("t5_idle_cancel_target", target, 32'd50);

        // 6: delay clamp, then asynchronous reset while pending
        $display("[TB] clamp and async reset");
        applyStimulus(32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_clamp_target", target, 32'h7FFF_FFFF);
        applyStimulus(32'h7FFF_FFFE, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_early_irq", {31'd0, irq}, 32'd0);
        applyStimulus(32'h7FFF_FFFF, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_irq", {31'd0, irq}, 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t6_rst_irq", {31'd0, irq}, 32'd0);
        checkOutput("t6_rst_target", target, 32'd0);
        checkOutput("t6_rst_active", {31'd0, active}, 32'd0);
        checkOutput("t6_rst_ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
        checkOutput("t6_rst_miss", {24'd0, miss_cnt}, 32'd0);
        #2 reset = 1'b1;
        applyStimulus(32'd5, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_post_active", {31'd0, active}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
